// File: rtl/gpu_isa_pkg.sv
// Shared ISA definitions for the GPU core: opcodes, instruction field
// positions, ALU select codes, the encoder FSM state type and the
// field-to-word packing function used by program_encoder.
package gpu_isa_pkg;

  // Opcodes (shared with the instruction decoder)
  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_BRNZP     = 4'h1;
  localparam logic [3:0] OP_CMP       = 4'h2;
  localparam logic [3:0] OP_ADD       = 4'h3;
  localparam logic [3:0] OP_SUB       = 4'h4;
  localparam logic [3:0] OP_MUL       = 4'h5;
  localparam logic [3:0] OP_DIV       = 4'h6;
  localparam logic [3:0] OP_LDR       = 4'h7;
  localparam logic [3:0] OP_STR       = 4'h8;
  localparam logic [3:0] OP_CONST     = 4'h9;
  localparam logic [3:0] OP_FIXED_MUL = 4'hA;
  localparam logic [3:0] OP_SLL       = 4'hB;
  localparam logic [3:0] OP_SRL       = 4'hC;
  localparam logic [3:0] OP_SRA       = 4'hD;
  localparam logic [3:0] OP_ILLEGAL   = 4'hE;
  localparam logic [3:0] OP_RET       = 4'hF;

  // Instruction word field positions
  localparam int OPCODE_HI = 15, OPCODE_LO = 12;
  localparam int RD_HI     = 11, RD_LO     = 8;
  localparam int RS_HI     = 7,  RS_LO     = 4;
  localparam int RT_HI     = 3,  RT_LO     = 0;
  localparam int NZP_HI    = 11, NZP_LO    = 9;
  localparam int IMM_HI    = 7,  IMM_LO    = 0;

  // ALU select codes
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_FMUL, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_sel_e;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} enc_state_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [2:0] nzp;
    logic [7:0] imm;
  } instr_fields_t;

  // Pack fields into a 16-bit word; fields an opcode does not use stay 0.
  function automatic logic [15:0] encode(input instr_fields_t f);
    logic [15:0] w;
    w = '0;
    w[OPCODE_HI:OPCODE_LO] = f.opcode;
    case (f.opcode)
      OP_NOP: w = '0;
      OP_BRNZP: begin
        w[NZP_HI:NZP_LO] = f.nzp;
        w[IMM_HI:IMM_LO] = f.imm;
      end
      OP_CMP, OP_STR: begin
        w[RS_HI:RS_LO] = f.rs;
        w[RT_HI:RT_LO] = f.rt;
      end
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_FIXED_MUL, OP_SLL, OP_SRL, OP_SRA: begin
        w[RD_HI:RD_LO] = f.rd;
        w[RS_HI:RS_LO] = f.rs;
        w[RT_HI:RT_LO] = f.rt;
      end
      OP_LDR: begin
        w[RD_HI:RD_LO] = f.rd;
        w[RS_HI:RS_LO] = f.rs;
      end
      OP_CONST: begin
        w[RD_HI:RD_LO]   = f.rd;
        w[IMM_HI:IMM_LO] = f.imm;
      end
      default: ; // RET (and the illegal code) carry the opcode only
    endcase
    return w;
  endfunction

endpackage

// File: rtl/program_encoder_if.sv
// Stream/bus bundle for program_encoder.
//   Instruction stream: in_valid/in_ready/in_last + opcode/rd/rs/rt/nzp/immediate
//   Memory write:       mem_write_valid/address/data, mem_write_ready
// slave  = encoder side (consumes instructions, issues memory writes)
// master = host/memory side
interface program_encoder_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [3:0]           in_opcode;
  logic [3:0]           in_rd;
  logic [3:0]           in_rs;
  logic [3:0]           in_rt;
  logic [2:0]           in_nzp;
  logic [7:0]           in_immediate;
  logic                 mem_write_valid;
  logic [ADDR_BITS-1:0] mem_write_address;
  logic [DATA_BITS-1:0] mem_write_data;
  logic                 mem_write_ready;

  modport slave (
    input  in_valid, in_last, in_opcode, in_rd, in_rs, in_rt, in_nzp, in_immediate,
    output in_ready,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport master (
    output in_valid, in_last, in_opcode, in_rd, in_rs, in_rt, in_nzp, in_immediate,
    input  in_ready,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous circular FIFO with full/empty flags.
//   wr_en/wr_data : enqueue (ignored when full)
//   rd_en         : dequeue (ignored when empty); rd_data shows the head
// Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp, rp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en && !full)  wp <= wp + 1'b1;
      if (rd_en && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wp[AW-1:0]] <= wr_data;
  end

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rd_data = mem[rp[AW-1:0]];
endmodule

// File: rtl/program_encoder.sv
// Instruction encoder / program loader.
//   clk, reset (async, active low), start, base_address
//   bus (slave): instruction field stream in, memory write handshake out
//   busy, done (1-cycle pulse), word_count, error ([0] illegal op, [1] overflow)
// Fields are packed into ISA words on accept, buffered in a FIFO and written
// to consecutive program memory addresses starting at base_address.
module program_encoder
  import gpu_isa_pkg::*;
#(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_BITS  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_address,
  program_encoder_if.slave     bus,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS:0]   word_count,
  output logic [1:0]           error
);
  enc_state_e           state, state_nx;
  logic [ADDR_BITS-1:0] wr_ptr;
  logic                 ptr_end;   // a write already went to the all-ones address
  instr_fields_t        fields;
  logic [DATA_BITS-1:0] word, head;
  logic                 accept, illegal, enq, deq, xfer, drop;
  logic                 fifo_full, fifo_empty;

  assign fields  = '{opcode: bus.in_opcode, rd: bus.in_rd, rs: bus.in_rs,
                     rt: bus.in_rt, nzp: bus.in_nzp, imm: bus.in_immediate};
  assign word    = encode(fields);
  assign accept  = bus.in_valid && bus.in_ready;
  assign illegal = (bus.in_opcode == OP_ILLEGAL);
  assign enq     = accept && !illegal;

  // Past the end of memory: words still drain from the FIFO but are discarded.
  assign drop = ptr_end || word_count[ADDR_BITS];
  assign bus.mem_write_valid   = !fifo_empty && !drop;
  assign bus.mem_write_address = wr_ptr;
  assign bus.mem_write_data    = bus.mem_write_valid ? head : '0;
  assign xfer = bus.mem_write_valid && bus.mem_write_ready;
  assign deq  = xfer || (!fifo_empty && drop);

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(reset),
    .wr_en(enq), .wr_data(word),
    .rd_en(deq), .rd_data(head),
    .full(fifo_full), .empty(fifo_empty)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_LOAD;
      ST_LOAD:  if (accept && bus.in_last) state_nx = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.in_ready = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      ST_LOAD:  begin bus.in_ready = !fifo_full; busy = 1'b1; end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  begin busy = 1'b1; done = 1'b1; end
      default:  ;
    endcase
  end

  // Write pointer, count and sticky errors
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      ptr_end    <= 1'b0;
      word_count <= '0;
      error      <= '0;
    end else if (state == ST_IDLE && start) begin
      wr_ptr     <= base_address;
      ptr_end    <= 1'b0;
      word_count <= '0;
      error      <= '0;
    end else begin
      if (xfer) begin
        word_count <= word_count + 1'b1;
        if (&wr_ptr) ptr_end <= 1'b1;   // hold at all-ones, never wrap
        else         wr_ptr  <= wr_ptr + 1'b1;
      end
      if (accept && illegal)     error[0] <= 1'b1;
      if (!fifo_empty && drop)   error[1] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_program_encoder.sv
module tb_program_encoder;
  import gpu_isa_pkg::*;
  localparam int AB = 8, DB = 16, FD = 4;

  logic          clk = 0, reset = 0, start = 0;
  logic [AB-1:0] base_address = '0;
  logic          busy, done;
  logic [AB:0]   word_count;
  logic [1:0]    error;

  program_encoder_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus();

  program_encoder #(.ADDR_BITS(AB), .DATA_BITS(DB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .start(start), .base_address(base_address),
    .bus(bus), .busy(busy), .done(done), .word_count(word_count), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op, rd, rs, rt;
    logic [2:0] nzp;
    logic [7:0] imm;
    logic       last;
    bit         has_exp;
    logic [15:0] exp;
  } beat_t;
  typedef struct { logic [AB-1:0] a; logic [DB-1:0] d; } wr_t;

  wr_t   exp_q[$];
  beat_t beats[$];
  int    total = 0, bad = 0;
  int    m_addr, m_wc, acc_cnt, done_cnt;
  logic [1:0] m_err;
  int    rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference: which fields each opcode carries, placed by plain arithmetic.
  function automatic logic [15:0] ref_word(input beat_t b);
    bit u_rd, u_rs, u_rt, u_imm, u_nzp;
    int w;
    {u_rd, u_rs, u_rt, u_imm, u_nzp} = '0;
    case (int'(b.op))
      1:                          begin u_nzp = 1; u_imm = 1; end
      2, 8:                       begin u_rs = 1; u_rt = 1; end
      3, 4, 5, 6, 10, 11, 12, 13: begin u_rd = 1; u_rs = 1; u_rt = 1; end
      7:                          begin u_rd = 1; u_rs = 1; end
      9:                          begin u_rd = 1; u_imm = 1; end
      default: ;
    endcase
    w = (b.op == 0) ? 0 : int'(b.op) * 4096;
    if (u_rd)  w += int'(b.rd) * 256;
    if (u_rs)  w += int'(b.rs) * 16;
    if (u_rt)  w += int'(b.rt);
    if (u_imm) w += int'(b.imm);
    if (u_nzp) w += int'(b.nzp) * 512;
    return w[15:0];
  endfunction

  function automatic beat_t mk(input int op, rd, rs, rt, nzp, imm, input bit last,
                               input bit has_exp = 0, input int exp = 0);
    beat_t b;
    b.op = op[3:0]; b.rd = rd[3:0]; b.rs = rs[3:0]; b.rt = rt[3:0];
    b.nzp = nzp[2:0]; b.imm = imm[7:0]; b.last = last;
    b.has_exp = has_exp; b.exp = exp[15:0];
    return b;
  endfunction

  function automatic beat_t rnd_beat(input bit last);
    return mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 255), last);
  endfunction

  // Model of an accepted beat: legal words go to consecutive addresses until
  // the top of memory; anything beyond is dropped and flags overflow.
  task automatic model_accept(input beat_t b);
    logic [15:0] w;
    acc_cnt++;
    if (b.op == 4'hE) m_err[0] = 1'b1;
    else begin
      w = b.has_exp ? b.exp : ref_word(b);
      if (m_addr <= 255) begin
        exp_q.push_back('{a: m_addr[AB-1:0], d: w});
        m_addr++;
        m_wc++;
      end else m_err[1] = 1'b1;
    end
  endtask

  task automatic send_beat(input beat_t b);
    bit ok = 0;
    bus.in_opcode = b.op; bus.in_rd = b.rd; bus.in_rs = b.rs; bus.in_rt = b.rt;
    bus.in_nzp = b.nzp; bus.in_immediate = b.imm; bus.in_last = b.last;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        ok = 1;
        model_accept(b);
      end
    end
    #1 bus.in_valid = 1'b0;
    if (!ok) begin total++; bad++; $display("FAIL accept_timeout: got no in_ready, want accept"); end
  endtask

  task automatic send_all();
    foreach (beats[i]) send_beat(beats[i]);
  endtask

  task automatic start_session(input logic [AB-1:0] base);
    @(posedge clk); #1;
    base_address = base; start = 1'b1;
    m_addr = int'(base); m_wc = 0; m_err = '0; acc_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    if (!ok) begin total++; bad++; $display("FAIL %s_timeout: busy stuck, want idle", tag); end
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_word_count"}, word_count, m_wc);
    chk({tag, "_error"}, error, m_err);
  endtask

  // Memory-side ready driver
  initial begin
    bus.mem_write_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.mem_write_ready = 1'b0;
        1:       bus.mem_write_ready = 1'b1;
        default: bus.mem_write_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pop on each transfer, stall stability, done count
  initial begin
    bit stall = 0;
    logic [AB-1:0] s_a;
    logic [DB-1:0] s_d;
    wr_t e;
    forever begin
      @(negedge clk);
      if (!reset) stall = 0;
      else begin
        if (done) done_cnt++;
        if (stall) begin
          chk("stall_valid", bus.mem_write_valid, 1);
          chk("stall_addr", bus.mem_write_address, s_a);
          chk("stall_data", bus.mem_write_data, s_d);
        end
        if (bus.mem_write_valid && bus.mem_write_ready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_write: got addr %0h data %0h, want no write",
                     bus.mem_write_address, bus.mem_write_data);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", bus.mem_write_address, e.a);
            chk("wr_data", bus.mem_write_data, e.d);
          end
          stall = 0;
        end else if (bus.mem_write_valid) begin
          stall = 1; s_a = bus.mem_write_address; s_d = bus.mem_write_data;
        end else stall = 0;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_wr_valid"}, bus.mem_write_valid, 0);
    chk({tag, "_wr_addr"}, bus.mem_write_address, 0);
    chk({tag, "_wr_data"}, bus.mem_write_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_word_count"}, word_count, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  initial begin
    bus.in_valid = 0; bus.in_last = 0; bus.in_opcode = 0; bus.in_rd = 0;
    bus.in_rs = 0; bus.in_rt = 0; bus.in_nzp = 0; bus.in_immediate = 0;
    #12 chk_all_zero("reset");
    @(negedge clk); reset = 1'b1;

    // Basic session
    rdy_mode = 1;
    beats = '{mk(3, 3, 4, 5, 0, 0, 0, 1, 'h3345), mk(9, 1, 7, 7, 7, 'h2A, 1, 1, 'h912A)};
    start_session(8'h10); send_all(); wait_done("basic");
    chk("basic_wc_lit", word_count, 2);
    chk("basic_err_lit", error, 0);

    // Field masking
    beats = '{mk(1, 15, 0, 0, 5, 'h10, 0, 1, 'h1A10), mk(7, 2, 6, 9, 7, 'hFF, 0, 1, 'h7260),
              mk(8, 7, 1, 2, 7, 'hFF, 0, 1, 'h8012), mk(15, 15, 15, 15, 7, 'hFF, 1, 1, 'hF000)};
    start_session(8'h20); send_all(); wait_done("mask");

    // Backpressure: 6 beats while memory stalls for 10 cycles
    rdy_mode = 0;
    beats.delete();
    for (int i = 0; i < 6; i++) beats.push_back(rnd_beat(i == 5));
    foreach (beats[i]) if (beats[i].op == 4'hE) beats[i].op = 4'h3;
    start_session(8'h40);
    fork
      send_all();
      begin
        repeat (10) @(negedge clk);
        chk("bp_accepts", acc_cnt, FD);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_valid_held", bus.mem_write_valid, 1);
        rdy_mode = 1;
      end
    join
    wait_done("bp");

    // Illegal opcode between two valid beats
    beats = '{mk(3, 1, 2, 3, 0, 0, 0), mk(14, 1, 1, 1, 1, 1, 0), mk(4, 4, 5, 6, 0, 0, 1)};
    start_session(8'h30); send_all(); wait_done("illegal");
    chk("illegal_err_lit", error, 2'b01);

    // Overflow at top of memory
    beats.delete();
    for (int i = 0; i < 4; i++) beats.push_back(mk(5, i, i + 1, i + 2, 0, 0, i == 3));
    start_session(8'hFE); send_all(); wait_done("ovf");
    chk("ovf_err_lit", error, 2'b10);
    chk("ovf_wc_lit", word_count, 2);

    // Random sessions
    for (int s = 0; s < 6; s++) begin
      int n = $urandom_range(3, 8);
      rdy_mode = 2;
      beats.delete();
      for (int i = 0; i < n; i++) beats.push_back(rnd_beat(i == n - 1));
      start_session(8'($urandom_range(0, 255)));
      send_all();
      wait_done("rand");
    end

    // Reset mid-drain with 3 words queued
    rdy_mode = 0;
    beats = '{mk(3, 1, 1, 1, 0, 0, 0), mk(4, 2, 2, 2, 0, 0, 0), mk(5, 3, 3, 3, 0, 0, 1)};
    start_session(8'h60); send_all();
    repeat (2) @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_valid", bus.mem_write_valid, 1);
    #2 reset = 1'b0;
    #1 chk_all_zero("abort");
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    rdy_mode = 1;
    beats = '{mk(11, 9, 8, 7, 0, 0, 0), mk(10, 1, 2, 3, 0, 0, 1)};
    start_session(8'h70); send_all(); wait_done("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
